// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform recorder: capture state machine encoding,
// CPU register map and CTRL/STATUS bit positions.
package waveform_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Avalon-MM word addresses
  localparam logic [1:0] REG_LENGTH = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // CTRL write bits
  localparam int unsigned START     = 0;
  localparam int unsigned CLEAR     = 1;
  // STATUS read bits
  localparam int unsigned BUSY      = 0;
  localparam int unsigned DONE      = 1;
  localparam int unsigned UNDERFLOW = 2;
  localparam int unsigned LEVEL_LSB = 16;

endpackage

// File: rtl/waveform_recorder_sync_fifo.sv
// Single-clock FIFO with synchronous flush and show-ahead read port.
// Ports:
//   clock, reset_n        - clock, synchronous active-low reset
//   i_flush               - empty the FIFO; a same-cycle push lands in the flushed FIFO
//   i_push, i_data        - write one entry (ignored when full)
//   i_pop                 - drop the head entry (ignored when empty or flushing)
//   o_data                - current head entry, valid whenever !o_empty
//   o_full, o_empty       - occupancy flags
//   o_level               - number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW-1:0]    w_wr_idx;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    o_full    = (r_level == (AW+1)'(DEPTH));
    o_empty   = (r_level == '0);
    o_level   = r_level;
    o_data    = r_mem[r_rd_ptr];
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty && !i_flush;
    // a push during flush is written to slot 0 of the freshly emptied FIFO
    w_wr_idx  = i_flush ? '0 : r_wr_ptr;
  end

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= w_do_push ? AW'(1) : '0;
      r_rd_ptr <= '0;
      r_level  <= (AW+1)'(w_do_push);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/waveform_recorder.sv
// Stereo capture recorder: pairs left/right Avalon-ST samples into frames,
// buffers them in a FIFO and lets the CPU drain them over Avalon-MM.
// Ports:
//   clock, reset_n                  - clock, synchronous active-low reset
//   address, write, writedata       - Avalon-MM write (LENGTH, CTRL)
//   read, readdata                  - Avalon-MM read, 1-cycle registered latency
//   l_audio_data/valid/ready        - left channel stream
//   r_audio_data/valid/ready        - right channel stream
module waveform_recorder
  import waveform_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic [SAMPLE_W-1:0] l_audio_data,
  input  logic                l_audio_valid,
  output logic                l_audio_ready,
  input  logic [SAMPLE_W-1:0] r_audio_data,
  input  logic                r_audio_valid,
  output logic                r_audio_ready
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FRAME_W = 2 * SAMPLE_W;

  state_t                r_state;
  state_t                w_next_state;
  logic [31:0]           r_length;
  logic [31:0]           r_count;
  logic [31:0]           r_readdata;
  logic                  r_underflow;
  logic                  r_l_held;
  logic                  r_r_held;
  logic [SAMPLE_W-1:0]   r_l_hold;
  logic [SAMPLE_W-1:0]   r_r_hold;

  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_clear;
  logic                  w_go;
  logic                  w_abort;
  logic                  w_push;
  logic                  w_data_rd;
  logic                  w_pop;
  logic                  w_l_acc;
  logic                  w_r_acc;
  logic                  w_full;
  logic                  w_empty;
  logic [FRAME_W-1:0]    w_head;
  logic [LVL_W-1:0]      w_level;
  logic [31:0]           w_status;
  logic [31:0]           w_head_word;

  always_comb begin
    w_ctrl_wr     = write && (address == REG_CTRL);
    w_start       = w_ctrl_wr && writedata[START];
    w_clear       = w_ctrl_wr && writedata[CLEAR];
    w_go          = w_start && (r_state != S_CAPTURE);
    w_abort       = w_ctrl_wr && !writedata[START] && (r_state == S_CAPTURE);
    // full is the pre-pop value, so a pop cannot make room for a same-cycle push
    w_push        = r_l_held && r_r_held && !w_full;
    w_data_rd     = read && (address == REG_DATA);
    w_pop         = w_data_rd && !w_empty;
    l_audio_ready = (r_state == S_CAPTURE) && !r_l_held;
    r_audio_ready = (r_state == S_CAPTURE) && !r_r_held;
    w_l_acc       = l_audio_valid && l_audio_ready;
    w_r_acc       = r_audio_valid && r_audio_ready;

    w_status            = '0;
    w_status[BUSY]      = (r_state == S_CAPTURE);
    w_status[DONE]      = (r_state == S_DONE);
    w_status[UNDERFLOW] = r_underflow;
    w_status[LEVEL_LSB +: 16] = 16'(w_level);
    w_head_word = {16'(w_head[FRAME_W-1:SAMPLE_W]), 16'(w_head[SAMPLE_W-1:0])};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CAPTURE: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else if (w_push && (r_count + 32'd1 == r_length)) begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        if (w_go) begin
          w_next_state = (r_length != '0) ? S_CAPTURE : S_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_length    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
      r_l_held    <= 1'b0;
      r_r_held    <= 1'b0;
      r_l_hold    <= '0;
      r_r_hold    <= '0;
      r_readdata  <= '0;
    end else begin
      if (write && (address == REG_LENGTH) && (r_state != S_CAPTURE)) begin
        r_length <= writedata;
      end

      if (w_go)        r_count <= '0;
      else if (w_push) r_count <= r_count + 32'd1;

      if (w_clear)                    r_underflow <= 1'b0;
      else if (w_data_rd && w_empty)  r_underflow <= 1'b1;

      // start, abort and push all leave both channel holds empty
      if (w_go || w_abort || w_push) r_l_held <= 1'b0;
      else if (w_l_acc)              r_l_held <= 1'b1;
      if (w_go || w_abort || w_push) r_r_held <= 1'b0;
      else if (w_r_acc)              r_r_held <= 1'b1;
      if (w_l_acc) r_l_hold <= l_audio_data;
      if (w_r_acc) r_r_hold <= r_audio_data;

      if (read) begin
        case (address)
          REG_LENGTH: r_readdata <= r_length;
          REG_CTRL:   r_readdata <= w_status;
          REG_DATA:   r_readdata <= w_empty ? '0 : w_head_word;
          default:    r_readdata <= r_count;
        endcase
      end
    end
  end

  assign readdata = r_readdata;

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_flush (w_clear),
    .i_push  (w_push),
    .i_data  ({r_l_hold, r_r_hold}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

endmodule

// File: tb/tb_waveform_recorder.sv
// Self-checking bench for waveform_recorder (FIFO_DEPTH=4, SAMPLE_W=16).
// A transaction-level model (frame queue, counters, hold flags) predicts
// readdata and the ready outputs every cycle; directed scenarios add
// hand-derived constants, followed by a randomized CPU/stream phase.
module tb_waveform_recorder;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [15:0] l_audio_data = '0;
  logic        l_audio_valid = 1'b0;
  logic        l_audio_ready;
  logic [15:0] r_audio_data = '0;
  logic        r_audio_valid = 1'b0;
  logic        r_audio_ready;

  waveform_recorder #(
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_W   (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .read          (read),
    .readdata      (readdata),
    .l_audio_data  (l_audio_data),
    .l_audio_valid (l_audio_valid),
    .l_audio_ready (l_audio_ready),
    .r_audio_data  (r_audio_data),
    .r_audio_valid (r_audio_valid),
    .r_audio_ready (r_audio_ready)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // stream generators: 0 = idle, 1 = always valid, 2 = random valid
  int unsigned l_gen = 0, r_gen = 0;
  int unsigned l_idx = 0, r_idx = 0;

  // reference model: 0 idle, 1 capturing, 2 done
  int unsigned m_mode = 0;
  logic [31:0] m_len = '0, m_cnt = '0, m_rd = '0;
  bit          m_uf = 0, m_lh = 0, m_rh = 0;
  logic [15:0] m_lv = '0, m_rv = '0;
  logic [31:0] m_q[$];

  task automatic model_reset();
    m_mode = 0; m_len = '0; m_cnt = '0; m_rd = '0;
    m_uf = 0; m_lh = 0; m_rh = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit cap, lacc, racc, push, ctrl;
    int unsigned lvl;
    logic [31:0] frame;
    cap   = (m_mode == 1);
    lacc  = l_audio_valid && cap && !m_lh;
    racc  = r_audio_valid && cap && !m_rh;
    lvl   = m_q.size();
    push  = m_lh && m_rh && (lvl < DEPTH);
    ctrl  = write && (address == 2'd1);
    frame = {m_lv, m_rv};
    if (read) begin
      case (address)
        2'd0:    m_rd = m_len;
        2'd1:    m_rd = {16'(lvl), 13'd0, m_uf, (m_mode == 2), cap};
        2'd2:    m_rd = (lvl > 0) ? m_q[0] : 32'd0;
        default: m_rd = m_cnt;
      endcase
    end
    if (ctrl && writedata[1]) begin
      m_q.delete();
      m_uf = 0;
    end else if (read && (address == 2'd2)) begin
      if (lvl > 0) void'(m_q.pop_front());
      else m_uf = 1;
    end
    if (push) begin
      m_q.push_back(frame);
      m_cnt++;
      m_lh = 0; m_rh = 0;
    end
    if (lacc) begin m_lh = 1; m_lv = l_audio_data; l_idx++; end
    if (racc) begin m_rh = 1; m_rv = r_audio_data; r_idx++; end
    if (ctrl && writedata[0] && !cap) begin
      m_cnt = '0; m_lh = 0; m_rh = 0;
      m_mode = (m_len != 0) ? 1 : 2;
    end else if (ctrl && !writedata[0] && cap) begin
      m_mode = 0; m_lh = 0; m_rh = 0;
    end else if (cap && push && (m_cnt == m_len)) begin
      m_mode = 2;
    end
    if (write && (address == 2'd0) && !cap) m_len = writedata;
  endtask

  // one clock cycle, entered and left at the falling edge
  task automatic tick();
    bit rd_now;
    l_audio_valid = (l_gen == 1) || (l_gen == 2 && $urandom_range(0, 1) == 1);
    r_audio_valid = (r_gen == 1) || (r_gen == 2 && $urandom_range(0, 1) == 1);
    l_audio_data  = 16'h1000 + 16'(l_idx);
    r_audio_data  = 16'h2000 + 16'(r_idx);
    #1;
    check_eq("l_ready", {31'd0, l_audio_ready}, {31'd0, (m_mode == 1) && !m_lh});
    check_eq("r_ready", {31'd0, r_audio_ready}, {31'd0, (m_mode == 1) && !m_rh});
    rd_now = read;
    model_step();
    @(posedge clock);
    #1;
    if (rd_now) check_eq("readdata", readdata, m_rd);
    @(negedge clock);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    tick();
    write = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a);
    read = 1'b1; address = a;
    tick();
    read = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; write = 1'b0; read = 1'b0;
    l_gen = 0; r_gen = 0; l_audio_valid = 1'b0; r_audio_valid = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_l_ready", {31'd0, l_audio_ready}, 32'd0);
    check_eq("rst_r_ready", {31'd0, r_audio_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin : main
    int unsigned op;
    int k;
    @(negedge clock);
    apply_reset();
    cpu_read(2'd1); check_eq("rst_status", readdata, 32'd0);
    cpu_read(2'd3); check_eq("rst_count", readdata, 32'd0);
    cpu_read(2'd0); check_eq("rst_length", readdata, 32'd0);

    // basic capture of four frames
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd4);
    cpu_write(2'd1, 32'd1);
    l_gen = 1; r_gen = 1;
    for (int c = 0; c < 60 && m_mode != 2; c++) tick();
    l_gen = 0; r_gen = 0;
    cpu_read(2'd1); check_eq("t1_status", readdata, 32'h0004_0002);
    cpu_read(2'd3); check_eq("t1_count", readdata, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd2);
      check_eq("t1_frame", readdata, 32'h1000_2000 + 32'(i) * 32'h0001_0001);
    end
    cpu_read(2'd1); check_eq("t1_drained", readdata, 32'h0000_0002);

    // skewed channels: L at cycle 0, R at cycle 5, push in cycle 6
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd1);
    cpu_write(2'd1, 32'd1);
    l_gen = 1;
    tick();
    l_gen = 0;
    for (int c = 1; c <= 5; c++) begin
      check_eq("t2_l_ready_low", {31'd0, l_audio_ready}, 32'd0);
      if (c == 5) r_gen = 1;
      tick();
    end
    r_gen = 0;
    cpu_read(2'd1); check_eq("t2_pre_push", readdata, 32'h0000_0001);
    cpu_read(2'd1); check_eq("t2_post_push", readdata, 32'h0001_0002);
    cpu_read(2'd2); check_eq("t2_frame", readdata, 32'h1000_2000);

    // FIFO full back-pressure with no CPU reads, then drain in order
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd10);
    cpu_write(2'd1, 32'd1);
    l_gen = 1; r_gen = 1;
    repeat (30) tick();
    cpu_read(2'd1); check_eq("t3_full_status", readdata, 32'h0004_0001);
    check_eq("t3_l_stalled", {31'd0, l_audio_ready}, 32'd0);
    check_eq("t3_r_stalled", {31'd0, r_audio_ready}, 32'd0);
    k = 0;
    for (int c = 0; c < 300 && k < 10; c++) begin
      if (m_q.size() > 0) begin
        cpu_read(2'd2);
        check_eq("t3_frame", readdata, 32'h1000_2000 + 32'(k) * 32'h0001_0001);
        k++;
      end else begin
        tick();
      end
    end
    l_gen = 0; r_gen = 0;
    check_eq("t3_frames_seen", 32'(k), 32'd10);
    cpu_read(2'd3); check_eq("t3_count", readdata, 32'd10);
    cpu_read(2'd1); check_eq("t3_status", readdata, 32'h0000_0002);

    // underflow and CLEAR
    cpu_read(2'd2); check_eq("t4_empty_pop", readdata, 32'd0);
    cpu_read(2'd1); check_eq("t4_underflow", readdata, 32'h0000_0006);
    cpu_write(2'd1, 32'd2);
    cpu_read(2'd1); check_eq("t4_cleared", readdata, 32'h0000_0002);

    // abort after two frames, then zero-length start
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd8);
    cpu_write(2'd1, 32'd1);
    l_gen = 1; r_gen = 1;
    for (int c = 0; c < 40 && m_cnt != 2; c++) tick();
    l_gen = 0; r_gen = 0;
    cpu_write(2'd1, 32'd0);
    cpu_read(2'd1); check_eq("t5_abort_status", readdata, 32'h0002_0000);
    cpu_read(2'd3); check_eq("t5_abort_count", readdata, 32'd2);
    cpu_read(2'd2); check_eq("t5_frame0", readdata, 32'h1000_2000);
    cpu_read(2'd2); check_eq("t5_frame1", readdata, 32'h1001_2001);
    cpu_write(2'd0, 32'd0);
    cpu_write(2'd1, 32'd1);
    cpu_read(2'd1); check_eq("t5_zero_len", readdata, 32'h0000_0002);
    cpu_read(2'd3); check_eq("t5_zero_count", readdata, 32'd0);

    // reset with level 3 and a lone left sample held
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd8);
    cpu_write(2'd1, 32'd1);
    l_gen = 1; r_gen = 1;
    for (int c = 0; c < 40 && m_q.size() != 3; c++) tick();
    r_gen = 0;
    for (int c = 0; c < 10 && !(m_lh && !m_rh); c++) tick();
    l_gen = 0;
    check_eq("t6_l_held", {31'd0, l_audio_ready}, 32'd0);
    apply_reset();
    cpu_read(2'd1); check_eq("t6_status", readdata, 32'd0);
    cpu_read(2'd3); check_eq("t6_count", readdata, 32'd0);
    cpu_read(2'd0); check_eq("t6_length", readdata, 32'd0);
    l_idx = 0; r_idx = 0;
    cpu_write(2'd0, 32'd2);
    cpu_write(2'd1, 32'd1);
    l_gen = 1; r_gen = 1;
    for (int c = 0; c < 40 && m_mode != 2; c++) tick();
    l_gen = 0; r_gen = 0;
    cpu_read(2'd1); check_eq("t6_restart", readdata, 32'h0002_0002);
    cpu_read(2'd2); check_eq("t6_frame0", readdata, 32'h1000_2000);
    cpu_read(2'd2); check_eq("t6_frame1", readdata, 32'h1001_2001);

    // randomized CPU traffic against random stream validity
    for (int run = 0; run < 4; run++) begin
      l_gen = 2; r_gen = 2;
      cpu_write(2'd0, 32'($urandom_range(1, 7)));
      cpu_write(2'd1, 32'($urandom_range(0, 3)));
      for (int t = 0; t < 150; t++) begin
        op = $urandom_range(0, 15);
        if (op < 4)       cpu_read(2'($urandom_range(0, 3)));
        else if (op == 4) cpu_write(2'd0, 32'($urandom_range(0, 6)));
        else if (op == 5) cpu_write(2'd1, 32'($urandom_range(0, 3)));
        else if (op == 6) cpu_write(2'($urandom_range(2, 3)), $urandom);
        else              tick();
      end
    end
    l_gen = 0; r_gen = 0;
    cpu_read(2'd1);
    cpu_read(2'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
